// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch with redirect handling and a decode-side queue (optional FETCH_ALIGN_CHECK_EN halts on odd redirect targets)
module fetch_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [WIDTH-1:0] imem_resp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_pc_2,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {FETCH, WAIT, DROP, HALT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic err_q, err_d;
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem [DEPTH];
  logic bad_tgt, push, pop, accept;
  logic [WIDTH-1:0] tgt;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bad_tgt = redirect_pc[0];
`else
  assign bad_tgt = 1'b0;
`endif
  assign tgt = redirect_pc & ~WIDTH'(1);
  assign imem_req_valid = !rst && state_q == FETCH && cnt_q < FULL && !redirect_valid;
  assign imem_req_addr = pc_q;
  assign accept = imem_req_valid && imem_req_ready;
  assign out_valid = !rst && cnt_q != '0;
  assign out_instr = instr_mem[rd_q];
  assign out_pc = pc_mem[rd_q];
  assign out_pc_2 = out_pc + WIDTH'(2);
  assign err = err_q;
  // a response is kept only in WAIT; a redirect in the same cycle discards it
  assign push = state_q == WAIT && imem_resp_valid && !redirect_valid;
  assign pop = out_valid && out_ready && !redirect_valid;
  // next-state: normal fetch/queue bookkeeping, then redirect flush overrides
  always_comb begin
    pc_d = accept ? pc_q + WIDTH'(2) : pc_q;
    state_d = accept ? WAIT : ((state_q == WAIT || state_q == DROP) && imem_resp_valid) ? FETCH : state_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    err_d = err_q;
    if (redirect_valid && state_q != HALT) begin
      pc_d = tgt;
      cnt_d = '0;
      wr_d = '0;
      rd_d = '0;
      state_d = bad_tgt ? HALT : (state_q == FETCH || imem_resp_valid) ? FETCH : DROP;
      err_d = err_q | bad_tgt;
    end
  end
  // control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      err_q <= err_d;
    end
  end
  // queue storage; the request PC is the fetch PC before its post-accept increment
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_q] <= imem_resp_data;
      pc_mem[wr_q] <= pc_q - WIDTH'(2);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a randomized-latency memory model
module tb_fetch_queue;
  localparam int W = 16;
  localparam logic [W-1:0] RPC = 16'h0000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, redirect_valid = 1'b0, imem_req_ready = 1'b0, imem_resp_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] redirect_pc = '0, imem_resp_data = '0;
  logic imem_req_valid, out_valid, err;
  logic [W-1:0] imem_req_addr, out_instr, out_pc, out_pc_2;
  int total = 0, bad = 0, accepts = 0, lat = 0, lat_min = 1, lat_max = 1;
  bit pend = 0, stale = 0;
  logic [W-1:0] pend_addr = '0;
  logic [W-1:0] exp_req[$];
  logic [W-1:0] exp_out[$];

  fetch_queue #(.WIDTH(W), .DEPTH(4), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_2(out_pc_2), .err(err)
  );

  function automatic logic [W-1:0] f(input logic [W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // program order after a restart point: sequential halfwords, wrapping at 2^16
  task automatic restart(input logic [W-1:0] t);
    exp_req.delete();
    exp_out.delete();
    for (int i = 0; i < 128; i++) begin
      exp_req.push_back(t + W'(2 * i));
      exp_out.push_back(t + W'(2 * i));
    end
  endtask

  task automatic cycle(input bit r, input bit rv, input logic [W-1:0] rpc, input bit ordy, input bit rdy);
    logic [W-1:0] want;
    @(negedge clk);
    rst = r;
    redirect_valid = rv;
    redirect_pc = rpc;
    out_ready = ordy;
    imem_req_ready = rdy;
    imem_resp_valid = 1'b0;
    imem_resp_data = W'($urandom);
    if (pend) begin
      if (lat == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data = f(pend_addr);
        pend = 0;
      end else lat--;
    end else if (stale && !r) begin
      imem_resp_valid = 1'b1;
      imem_resp_data = 16'hDEAD;
      stale = 0;
    end
    if (r && pend) begin
      pend = 0;
      stale = 1;
    end
    if (r) restart(RPC);
    else if (rv) restart(rpc & ~16'h0001);
    #2;
    if (r || rv) check("req_valid_blocked", {31'b0, imem_req_valid}, 0);
    if (r) check("out_valid_in_rst", {31'b0, out_valid}, 0);
    if (imem_req_valid && imem_req_ready) begin
      accepts++;
      check("one_outstanding", {31'b0, pend}, 0);
      want = exp_req.size() != 0 ? exp_req.pop_front() : 'x;
      check("req_addr", {16'b0, imem_req_addr}, {16'b0, want});
      pend = 1;
      pend_addr = imem_req_addr;
      lat = $urandom_range(lat_max, lat_min) - 1;
    end
  endtask

  // monitor: every handshake outside reset/redirect cycles must deliver the next program-order entry
  initial forever begin
    logic [W-1:0] e;
    @(negedge clk);
    #3;
    if (!rst && !redirect_valid && out_valid && out_ready) begin
      if (exp_out.size() == 0) check("out_unexpected", {16'b0, out_pc}, 'x);
      else begin
        e = exp_out.pop_front();
        check("out_pc", {16'b0, out_pc}, {16'b0, e});
        check("out_instr", {16'b0, out_instr}, {16'b0, f(e)});
        check("out_pc_2", {16'b0, out_pc_2}, {16'b0, e + 16'd2});
        check("err", {31'b0, err}, 0);
      end
    end
  end

  initial begin
    int a0;
    bit seen;
    restart(RPC);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    // 1-cycle memory: requests on alternate cycles
    a0 = accepts;
    repeat (6) cycle(0, 0, 0, 1, 1);
    check("alt_cycle_reqs", accepts - a0, 3);
    // stalled decode fills the queue exactly, then one pop frees one request
    cycle(1, 0, 0, 0, 1);
    a0 = accepts;
    repeat (20) cycle(0, 0, 0, 0, 1);
    check("fill_reqs", accepts - a0, 4);
    check("full_req_low", {31'b0, imem_req_valid}, 0);
    check("full_out_valid", {31'b0, out_valid}, 1);
    cycle(0, 0, 0, 1, 1);
    repeat (6) cycle(0, 0, 0, 0, 1);
    check("refill_one", accepts - a0, 5);
    // redirect while a 3-cycle response is pending
    lat_min = 3; lat_max = 3;
    cycle(1, 0, 0, 1, 1);
    for (int k = 0; k < 10 && !pend; k++) cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    check("pending_before_redirect", {31'b0, pend}, 1);
    cycle(0, 1, 16'h0040, 1, 1);
    cycle(0, 0, 0, 0, 1);
    check("flush_empty", {31'b0, out_valid}, 0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle(0, 0, 0, 0, 1);
      seen = out_valid;
    end
    check("redirect_head_valid", {31'b0, seen}, 1);
    check("redirect_head", {16'b0, out_pc}, 32'h0040);
    // wrap at the top of the address space
    lat_min = 1; lat_max = 1;
    cycle(0, 1, 16'hFFFC, 1, 1);
    for (int k = 0; k < 12; k++) begin
      cycle(0, 0, 0, 1, 1);
      if (out_valid && out_pc == 16'hFFFE) check("wrap_pc2", {16'b0, out_pc_2}, 0);
    end
    // odd redirect target is aligned down, no error in this build
    cycle(0, 1, 16'h0011, 1, 1);
    repeat (4) cycle(0, 0, 0, 1, 1);
    check("err_low", {31'b0, err}, 0);
    // reset while waiting with two entries queued
    lat_min = 3; lat_max = 3;
    cycle(1, 0, 0, 0, 1);
    repeat (9) cycle(0, 0, 0, 0, 1);
    check("wait_before_rst", {31'b0, pend}, 1);
    check("queued_before_rst", {31'b0, out_valid}, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check("post_rst_empty", {31'b0, out_valid}, 0);
    repeat (10) cycle(0, 0, 0, 1, 1);
    // randomized traffic
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 3000; k++) begin
      bit r, rv;
      logic [W-1:0] t;
      r = ($urandom % 200) == 0;
      rv = !r && ($urandom % 25) == 0;
      t = ($urandom % 4) == 0 ? (16'hFFF0 | W'($urandom % 16)) : W'($urandom);
      cycle(r, rv, t, ($urandom % 10) < 7, ($urandom % 10) < 7);
    end
    repeat (20) cycle(0, 0, 0, 1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning address/instruction width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 16'h0000, meaning PC loaded on reset.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk input 1 (all state on rising edge), rst input 1.
REQ-005 SHALL have port redirect_valid input 1, branch/jump redirect request.
REQ-006 SHALL have port redirect_pc input WIDTH, redirect target.
REQ-007 SHALL have port imem_req_valid output 1, fetch request to instruction memory.
REQ-008 SHALL have port imem_req_ready input 1, memory accepts request.
REQ-009 SHALL have port imem_req_addr output WIDTH, fetch address.
REQ-010 SHALL have port imem_resp_valid input 1, instruction returned, in order, >=1 cycle after acceptance.
REQ-011 SHALL have port imem_resp_data input WIDTH, returned instruction.
REQ-012 SHALL have port out_valid output 1, queue head valid.
REQ-013 SHALL have port out_ready input 1, decode consumes head.
REQ-014 SHALL have port out_instr output WIDTH, head instruction.
REQ-015 SHALL have port out_pc output WIDTH, head PC.
REQ-016 SHALL have port out_pc_2 output WIDTH, head PC + 2 modulo 2^WIDTH.
REQ-017 SHALL have port err output 1, sticky fetch error.

Function
REQ-018 States: FETCH (no request outstanding), WAIT (one outstanding, keep), DROP (one outstanding, discard), HALT (error); at most one request outstanding.
REQ-019 In FETCH, imem_req_valid=1 iff count+0 < DEPTH, redirect_valid=0 and state!=HALT; imem_req_addr=fetch PC.
REQ-020 Request accepted when imem_req_valid & imem_req_ready: fetch PC += 2 (wraps at 2^WIDTH), state -> WAIT.
REQ-021 In WAIT, imem_resp_valid pushes {resp_data, request PC} into queue, state -> FETCH; next request may issue the following cycle.
REQ-022 Queue push and pop in same cycle SHALL both occur, count unchanged; pop only when out_valid & out_ready.
REQ-023 Queue full (count==DEPTH) SHALL hold imem_req_valid low; no request issues unless a slot is reserved for its response.
REQ-024 out_valid = (count!=0); out_instr/out_pc/out_pc_2 driven combinationally from head; head stable while out_valid & !out_ready.
REQ-025 redirect_valid in cycle N: queue flushed (count=0 at N+1), fetch PC=redirect_pc at N+1, imem_req_valid=0 in cycle N; first request addr=redirect_pc at N+1 (if memory idle).
REQ-026 Redirect while WAIT -> DROP; response arriving in DROP discarded, state -> FETCH; response arriving in redirect cycle itself discarded.
REQ-027 Redirect while DROP stays DROP with new target; last redirect wins.
REQ-028 imem_resp_valid in FETCH or HALT SHALL be ignored.
REQ-029 Pop in redirect cycle is honoured at the interface but has no effect beyond the flush.

Reset
REQ-030 rst=1 at edge: fetch PC=RESET_PC, count=0, pointers 0, state FETCH, err=0; overrides redirect and responses that cycle.
REQ-031 While rst=1: imem_req_valid=0, out_valid=0; first request (addr RESET_PC) may issue the cycle after rst deasserts.
REQ-032 Reset mid-operation abandons outstanding request; its late response falls under REQ-028.

Configuration
REQ-033 Macro FETCH_ALIGN_CHECK_EN defined: redirect_pc[0]=1 sets err=1, state -> HALT, queue flushed, no further requests until reset.
REQ-034 Macro undefined: redirect_pc[0] forced to 0 when loaded, err tied to 0, HALT unreachable.

Verification
REQ-035 Reset, imem_req_ready=1, 1-cycle memory, out_ready=1 -> requests 0x0000,0x0002,0x0004 on consecutive alternate cycles; out_pc matches, out_pc_2=out_pc+2.
REQ-036 out_ready=0, DEPTH=4 -> exactly 4 entries fill, imem_req_valid stays 0; out_ready=1 for one cycle -> one new request issues.
REQ-037 Redirect to 0x0040 while WAIT (3-cycle memory) -> pending response dropped, queue empty, next out_pc=0x0040.
REQ-038 Fetch PC=0xFFFE -> next request addr 0x0000, out_pc_2 of 0xFFFE entry = 0x0000.
REQ-039 With FETCH_ALIGN_CHECK_EN, redirect_pc=0x0011 -> err=1 next cycle, imem_req_valid=0 until rst; without it, fetch from 0x0010, err=0.
REQ-040 rst asserted while WAIT with 2 queued -> next cycle out_valid=0, late resp ignored, first request addr=RESET_PC.
